// File: rtl/kyber_axi_pkg.sv
// Shared AXI constants, FSM state encoding and burst helpers for the
// Kyber accelerator AXI initiator.
//
// Contents:
//   AXI_SIZE_128, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_BUF  - fixed AXI attributes
//   ST_*                                                         - axi_burst_master FSM states
//   crosses_4k()                                                 - 4KB boundary test for a burst
package kyber_axi_pkg;

    localparam logic [2:0] AXI_SIZE_128   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    // True when a burst of (len+1) 16-byte beats starting at the 16-byte
    // aligned page offset addr_lo runs past the end of its 4KB page.
    // 13 bits hold the worst case 4080 + 4096.
    function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len);
        logic [12:0] w_bytes;
        logic [12:0] w_end;
        w_bytes = {({1'b0, len} + 9'd1), 4'b0000};
        w_end   = {1'b0, addr_lo} + w_bytes;
        return (w_end > 13'd4096);
    endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter for one AXI burst.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   i_clear    - zero the counter (new command)
//   i_inc      - one beat transferred
//   i_len      - burst length minus one
//   o_is_last  - current beat is the final beat of the burst
//
// The counter is 9 bits so a 256-beat burst (len = 255) never wraps back
// to a value that would match len a second time.
module axi_beat_counter
    import kyber_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_inc,
    input  logic [7:0] i_len,
    output logic       o_is_last
);

    logic [8:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 9'd0;
        end else if (i_clear) begin
            r_count <= 9'd0;
        end else if (i_inc) begin
            r_count <= r_count + 9'd1;
        end
    end

    assign o_is_last = (r_count == {1'b0, i_len});

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 initiator issuing 128-bit INCR bursts into the Kyber accelerator
// slave port, one command at a time.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake; cmd_write, cmd_addr, cmd_len payload
//   wr_valid/wr_ready/wr_data - local write stream (write bursts)
//   rd_valid/rd_ready/rd_data/rd_last - local read stream (read bursts)
//   done, err                - one-cycle completion pulse and its error flag
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r* - AXI4 master channels
//
// The W and R data paths are combinational pass-throughs between the local
// streams and the AXI channels, gated by the FSM state; only the address,
// length, state, beat count and sticky error are registered.
module axi_burst_master
    import kyber_axi_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic                  err,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [3:0]            m_axi_awcache,
    output logic                  m_axi_awlock,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic                  m_axi_arlock,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic              r_err;

    logic [ADDR_W-1:0] w_addr_aligned;
    logic              w_cross;
    logic              w_accept;
    logic              w_w_fire;
    logic              w_r_fire;
    logic              w_is_last;

    // Beat address bits are dropped: every beat is a full 16-byte word.
    assign w_addr_aligned = cmd_addr & ~ADDR_W'(4'hF);
    assign w_cross        = crosses_4k(w_addr_aligned[11:0], cmd_len);

    // cmd_ready is masked by rst so it reads 0 while reset is held.
    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_w_fire  = (r_state == ST_W) && wr_valid && m_axi_wready;
    assign w_r_fire  = (r_state == ST_R) && m_axi_rvalid && rd_ready;

    axi_beat_counter u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_inc     (w_w_fire || w_r_fire),
        .i_len     (r_len),
        .o_is_last (w_is_last)
    );

    // Command stage: next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = w_cross ? ST_FIN : (cmd_write ? ST_AW : ST_AR);
            ST_AW:   if (m_axi_awready) w_next = ST_W;
            ST_W:    if (w_w_fire && w_is_last) w_next = ST_B;
            ST_B:    if (m_axi_bvalid)  w_next = ST_FIN;
            ST_AR:   if (m_axi_arready) w_next = ST_R;
            ST_R:    if (w_r_fire && w_is_last) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address and length are payload only; the valids qualify them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= w_addr_aligned;
            r_len  <= cmd_len;
        end
    end

    // Sticky error: seeded by the 4KB check, accumulated from responses,
    // cleared as it is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_err <= w_cross;
                ST_B:    if (m_axi_bvalid) r_err <= r_err | (m_axi_bresp != AXI_RESP_OKAY);
                ST_R:    if (w_r_fire)
                             r_err <= r_err | (m_axi_rresp != AXI_RESP_OKAY)
                                            | (m_axi_rlast != w_is_last);
                ST_FIN:  r_err <= 1'b0;
                default: r_err <= r_err;
            endcase
        end
    end

    // Output stage: AXI channels and local streams
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = AXI_SIZE_128;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awcache = AXI_CACHE_BUF;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (r_state == ST_AW);

    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (r_state == ST_W) && w_is_last;
    assign m_axi_wvalid  = (r_state == ST_W) && wr_valid;
    assign wr_ready      = (r_state == ST_W) && m_axi_wready;

    assign m_axi_bready  = (r_state == ST_B);

    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = AXI_SIZE_128;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arcache = AXI_CACHE_BUF;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state == ST_AR);

    assign rd_valid      = (r_state == ST_R) && m_axi_rvalid;
    assign m_axi_rready  = (r_state == ST_R) && rd_ready;
    assign rd_data       = m_axi_rdata;
    assign rd_last       = (r_state == ST_R) && w_is_last;

    assign done          = (r_state == ST_FIN);
    assign err           = (r_state == ST_FIN) && r_err;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a table of commands run against an AXI slave
// model (zero-wait or random-stall), plus hand-written reset sequences.
module tb_axi_burst_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [16:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic         wr_valid, wr_ready;
    logic [127:0] wr_data;
    logic         rd_valid, rd_ready, rd_last;
    logic [127:0] rd_data;
    logic         done, err;
    logic [16:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic [3:0]   awcache, arcache;
    logic         awlock, arlock, awvalid, awready, arvalid, arready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    axi_burst_master #(.ADDR_W(17), .DATA_W(128)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awlock(awlock),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arlock(arlock),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          s_seed, s_err_beat, s_rlast_beat;
    bit          s_stall;
    logic [1:0]  s_bresp;
    logic        rnd_aw, rnd_w, rnd_b, rnd_ar, rnd_r;
    logic        aw_seen, b_pend, r_act, prev_aw_wait, prev_ar_wait;
    logic [16:0] prev_awaddr, prev_araddr, cap_awaddr, cap_araddr;
    logic [7:0]  cap_awlen, cap_arlen, r_len;
    int          w_idx, r_beat;
    int          aw_cnt = 0, ar_cnt = 0, w_cnt = 0, w_bad = 0, axv_cnt = 0;
    int          attr_bad = 0, early_w = 0, stab_bad = 0;

    assign awready = rnd_aw;
    assign wready  = rnd_w;
    assign arready = rnd_ar;
    assign bresp   = s_bresp;
    assign rdata   = 128'(r_beat + 1);
    assign rresp   = (r_beat == s_err_beat) ? 2'b10 : 2'b00;
    assign rlast   = (r_beat == s_rlast_beat);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_aw <= 0; rnd_w <= 0; rnd_b <= 0; rnd_ar <= 0; rnd_r <= 0;
            aw_seen <= 0; b_pend <= 0; bvalid <= 0; r_act <= 0; rvalid <= 0;
            w_idx <= 0; r_beat <= 0; prev_aw_wait <= 0; prev_ar_wait <= 0;
        end else begin
            rnd_aw <= s_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_w  <= s_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_b  <= s_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_ar <= s_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_r  <= s_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (awvalid || arvalid) axv_cnt <= axv_cnt + 1;
            if (prev_aw_wait && (!awvalid || awaddr != prev_awaddr)) stab_bad <= stab_bad + 1;
            if (prev_ar_wait && (!arvalid || araddr != prev_araddr)) stab_bad <= stab_bad + 1;
            prev_aw_wait <= awvalid && !awready;  prev_awaddr <= awaddr;
            prev_ar_wait <= arvalid && !arready;  prev_araddr <= araddr;
            if (awvalid && awready) begin
                aw_cnt <= aw_cnt + 1; cap_awaddr <= awaddr; cap_awlen <= awlen;
                aw_seen <= 1; w_idx <= 0;
                if (awsize != 3'b100 || awburst != 2'b01 || awcache != 4'b0011 || awlock || awprot != 0)
                    attr_bad <= attr_bad + 1;
            end
            if (wvalid && !aw_seen) early_w <= early_w + 1;
            if (wvalid && wready) begin
                w_cnt <= w_cnt + 1;
                if (wdata !== {64'(s_seed), 64'(w_idx)} || wlast !== (w_idx == int'(cap_awlen)) || wstrb !== 16'hFFFF)
                    w_bad <= w_bad + 1;
                w_idx <= w_idx + 1;
                if (wlast) begin
                    if (rnd_b) bvalid <= 1; else b_pend <= 1;
                end
            end
            if (b_pend && rnd_b) begin bvalid <= 1; b_pend <= 0; end
            if (bvalid && bready) begin bvalid <= 0; aw_seen <= 0; end
            if (arvalid && arready) begin
                ar_cnt <= ar_cnt + 1; cap_araddr <= araddr; cap_arlen <= arlen;
                r_len <= arlen; r_beat <= 0; r_act <= 1;
                if (rnd_r) rvalid <= 1;
                if (arsize != 3'b100 || arburst != 2'b01 || arcache != 4'b0011 || arlock || arprot != 0)
                    attr_bad <= attr_bad + 1;
            end
            if (rvalid && rready) begin
                if (r_beat == int'(r_len)) begin rvalid <= 0; r_act <= 0; end
                else begin r_beat <= r_beat + 1; rvalid <= rnd_r; end
            end else if (r_act && !rvalid && rnd_r) begin
                rvalid <= 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [16:0] addr;
        logic [7:0]  len;
        bit          stall;
        int          err_beat;
        int          rlast_beat;   // -1: rlast on the true final beat
        logic [1:0]  bresp;
        bit          exp_err;
        bit          exp_xfer;
        int          exp_lat;      // -1: latency not checked
    } vec_t;

    vec_t vecs[13];

    bit   abort, mon_seen, mon_fin, mon_err, post_done, post_rdy;
    int   mon_lat, rd_cnt, rd_bad;

    task automatic producer(input int len, input bit stall, input int seed);
        int k = 0; int guard = 0; bit fire = 0;
        wr_valid = 0;
        while (!abort && guard < 3000) begin
            @(negedge clk); guard++;
            if (abort) break;
            if (fire) k++;
            if (k > len) break;
            if (fire || !wr_valid) begin
                wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                wr_data  = {64'(seed), 64'(k)};
            end
            fire = wr_valid && wr_ready;
        end
        wr_valid = 0;
    endtask

    task automatic consumer(input int len, input bit stall);
        int k = 0; int guard = 0;
        while (!mon_fin && guard < 3000) begin
            @(negedge clk); guard++;
            rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) begin
                if (rd_data !== 128'(k + 1) || rd_last !== (k == len)) rd_bad++;
                k++;
            end
        end
        rd_ready = 0;
        rd_cnt = k;
    endtask

    task automatic monitor();
        int cyc = 0;
        mon_seen = 0; post_done = 1'bx; post_rdy = 1'bx;
        while (!mon_seen && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (cyc == 1) cmd_valid = 0;
            if (done) begin mon_seen = 1; mon_lat = cyc; mon_err = err; end
        end
        if (mon_seen) begin
            @(negedge clk);
            post_done = done; post_rdy = cmd_ready;
        end
        mon_fin = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int aw0, ar0, w0, wb0, av0, g;
        string p;
        p = $sformatf("v%0d", idx);
        aw0 = aw_cnt; ar0 = ar_cnt; w0 = w_cnt; wb0 = w_bad; av0 = axv_cnt;
        s_seed = idx; s_stall = v.stall; s_err_beat = v.err_beat; s_bresp = v.bresp;
        s_rlast_beat = (v.rlast_beat < 0) ? int'(v.len) : v.rlast_beat;
        rd_cnt = 0; rd_bad = 0; mon_fin = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        check({p, "_cmd_ready"}, cmd_ready, 1);
        @(posedge clk);
        fork
            begin if (v.wr && v.exp_xfer) producer(int'(v.len), v.stall, idx); end
            begin if (!v.wr && v.exp_xfer) consumer(int'(v.len), v.stall); end
            monitor();
        join
        check({p, "_done_seen"}, mon_seen, 1);
        check({p, "_err"}, mon_err, v.exp_err);
        if (v.exp_lat >= 0) check({p, "_latency"}, mon_lat, v.exp_lat);
        check({p, "_done_pulse"}, post_done, 0);
        check({p, "_ready_after"}, post_rdy, 1);
        check({p, "_aw_count"}, aw_cnt - aw0, (v.wr && v.exp_xfer) ? 1 : 0);
        check({p, "_ar_count"}, ar_cnt - ar0, (!v.wr && v.exp_xfer) ? 1 : 0);
        if (!v.exp_xfer) check({p, "_no_axi_valid"}, axv_cnt - av0, 0);
        if (v.wr && v.exp_xfer) begin
            check({p, "_w_beats"}, w_cnt - w0, int'(v.len) + 1);
            check({p, "_w_bad"}, w_bad - wb0, 0);
            check({p, "_awaddr"}, cap_awaddr, v.addr & 17'h1FFF0);
            check({p, "_awlen"}, cap_awlen, v.len);
        end
        if (!v.wr && v.exp_xfer) begin
            check({p, "_rd_beats"}, rd_cnt, int'(v.len) + 1);
            check({p, "_rd_bad"}, rd_bad, 0);
            check({p, "_araddr"}, cap_araddr, v.addr & 17'h1FFF0);
            check({p, "_arlen"}, cap_arlen, v.len);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0; abort = 0;
        s_seed = 0; s_stall = 0; s_err_beat = -1; s_rlast_beat = 0; s_bresp = 0;

        //             wr addr      len  st errb rlb bresp err xfer lat
        vecs[0]  = '{1, 17'h10000, 3,   0, -1, -1, 2'b00, 0, 1, 7};
        vecs[1]  = '{0, 17'h00010, 0,   0, -1, -1, 2'b00, 0, 1, 3};
        vecs[2]  = '{1, 17'h00FF0, 1,   0, -1, -1, 2'b00, 1, 0, 1};
        vecs[3]  = '{0, 17'h02000, 7,   0,  5, -1, 2'b00, 1, 1, 10};
        vecs[4]  = '{0, 17'h00100, 3,   0, -1,  2, 2'b00, 1, 1, 6};
        vecs[5]  = '{1, 17'h00400, 0,   0, -1, -1, 2'b11, 1, 1, 4};
        vecs[6]  = '{1, 17'h00F00, 15,  0, -1, -1, 2'b00, 0, 1, 19};
        vecs[7]  = '{1, 17'h10F0F, 15,  0, -1, -1, 2'b00, 0, 1, 19};
        vecs[8]  = '{0, 17'h00000, 255, 0, -1, -1, 2'b00, 0, 1, 258};
        vecs[9]  = '{1, 17'h00010, 255, 0, -1, -1, 2'b00, 1, 0, 1};
        vecs[10] = '{1, 17'h03000, 7,   1, -1, -1, 2'b00, 0, 1, -1};
        vecs[11] = '{0, 17'h05020, 9,   1, -1, -1, 2'b00, 0, 1, -1};
        vecs[12] = '{0, 17'h01FF0, 1,   0, -1, -1, 2'b00, 1, 0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, done, err}, 9'b0);
        rst = 0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Reset while W beat 2 of a 16-beat write is presented
        s_seed = 20; s_stall = 0; s_err_beat = -1; s_rlast_beat = 15; s_bresp = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 17'h00200; cmd_len = 8'd15;
        @(posedge clk);
        fork producer(15, 1'b0, 20); join_none
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (c == 0) cmd_valid = 0;
            if (wvalid && w_idx == 2) found = 1;
        end
        check("rst_mid_reached_beat2", found, 1);
        rst = 1;
        #1;
        check("rst_mid_outputs",
              {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done, err}, 10'b0);
        abort = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        abort = 0;
        run_vec(vecs[0], 0);
        run_vec(vecs[1], 1);

        check("attr_bad", attr_bad, 0);
        check("w_before_aw", early_w, 0);
        check("addr_stability", stab_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
